// File: rtl/dmni_mem_arbiter.sv
// Arbitrates a single-port local memory between the DMNI DMA engine (absolute
// priority) and the CPU, with read-data steering, starvation flag and stall counter.
module dmni_mem_arbiter #(
    parameter int STARVE_LIMIT = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 dmni_req_i,
    input  logic [3:0]           dmni_we_i,
    input  logic [31:0]          dmni_addr_i,
    input  logic [31:0]          dmni_wdata_i,
    output logic [31:0]          dmni_rdata_o,
    input  logic                 cpu_req_i,
    input  logic [3:0]           cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    output logic                 cpu_gnt_o,
    output logic                 cpu_rvalid_o,
    output logic [31:0]          cpu_rdata_o,
    output logic                 cpu_starve_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [3:0]           mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    input  logic [31:0]          mem_rdata_i
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMNI = 2'd2
    } owner_e;

    owner_e              owner_r;
    owner_e              owner_next_s;
    logic                dmni_sel_s;
    logic                cpu_sel_s;
    logic                cpu_stall_s;
    logic [31:0]         addr_hold_r;
    logic [31:0]         wdata_hold_r;
    logic [31:0]         cpu_rdata_r;
    logic [WAIT_W-1:0]   wait_r;
    logic [WAIT_W-1:0]   wait_next_s;
    logic                starve_r;
    logic [CNT_WIDTH-1:0] stall_cnt_r;

    // Nothing owns the memory while reset is held, so no write can leak out.
    assign dmni_sel_s  = rst_ni & dmni_req_i;
    assign cpu_sel_s   = rst_ni & ~dmni_req_i & cpu_req_i;
    assign cpu_stall_s = cpu_req_i & ~cpu_sel_s;

    // Memory port steering: DMNI first, then CPU, otherwise park on last address/data.
    always_comb begin
        mem_we_o    = 4'h0;
        mem_addr_o  = addr_hold_r;
        mem_wdata_o = wdata_hold_r;
        if (dmni_sel_s) begin
            mem_we_o    = dmni_we_i;
            mem_addr_o  = dmni_addr_i;
            mem_wdata_o = dmni_wdata_i;
        end else if (cpu_sel_s) begin
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
        end else begin
            mem_we_o    = 4'h0;
        end
    end

    // Who will own the read data returning next cycle.
    always_comb begin
        owner_next_s = OWN_NONE;
        if (dmni_sel_s) begin
            owner_next_s = OWN_DMNI;
        end else if (cpu_sel_s && (cpu_we_i == 4'h0)) begin
            owner_next_s = OWN_CPU;
        end else begin
            owner_next_s = OWN_NONE;
        end
    end

    // Consecutive-wait counter, saturating at the starvation threshold.
    always_comb begin
        wait_next_s = {WAIT_W{1'b0}};
        if (cpu_stall_s) begin
            if (wait_r >= WAIT_W'(STARVE_LIMIT)) begin
                wait_next_s = wait_r;
            end else begin
                wait_next_s = wait_r + WAIT_W'(1);
            end
        end else begin
            wait_next_s = {WAIT_W{1'b0}};
        end
    end

    // Arbiter state: parked bus values, read owner, CPU data, starvation and stall stats.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_r      <= OWN_NONE;
            addr_hold_r  <= 32'h0000_0000;
            wdata_hold_r <= 32'h0000_0000;
            cpu_rdata_r  <= 32'h0000_0000;
            wait_r       <= {WAIT_W{1'b0}};
            starve_r     <= 1'b0;
            stall_cnt_r  <= {CNT_WIDTH{1'b0}};
        end else begin
            owner_r <= owner_next_s;
            if (dmni_sel_s || cpu_sel_s) begin
                addr_hold_r  <= mem_addr_o;
                wdata_hold_r <= mem_wdata_o;
            end
            if (owner_r == OWN_CPU) begin
                cpu_rdata_r <= mem_rdata_i;
            end
            wait_r   <= wait_next_s;
            starve_r <= (wait_next_s >= WAIT_W'(STARVE_LIMIT));
            if (cpu_stall_s && (stall_cnt_r != {CNT_WIDTH{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_WIDTH'(1);
            end
        end
    end

    // Returning read data is forwarded to the CPU in the cycle it arrives, then held.
    assign dmni_rdata_o = mem_rdata_i;
    assign cpu_gnt_o    = cpu_sel_s;
    assign cpu_rvalid_o = (owner_r == OWN_CPU);
    assign cpu_rdata_o  = (owner_r == OWN_CPU) ? mem_rdata_i : cpu_rdata_r;
    assign cpu_starve_o = starve_r;
    assign stall_cnt_o  = stall_cnt_r;

endmodule

// File: tb/tb_dmni_mem_arbiter.sv
// Bench for dmni_mem_arbiter: directed scenarios then randomized traffic, all
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_dmni_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        dmni_req_i;
    logic [3:0]  dmni_we_i;
    logic [31:0] dmni_addr_i, dmni_wdata_i, dmni_rdata_o;
    logic        cpu_req_i;
    logic [3:0]  cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
    logic        cpu_gnt_o, cpu_rvalid_o, cpu_starve_o;
    logic [15:0] stall_cnt_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    logic [31:0] dmni_rdata4, cpu_rdata4, mem_addr4, mem_wdata4;
    logic        cpu_gnt4, cpu_rvalid4, cpu_starve4;
    logic [3:0]  stall_cnt4, mem_we4;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    dmni_mem_arbiter u_dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .dmni_req_i(dmni_req_i), .dmni_we_i(dmni_we_i), .dmni_addr_i(dmni_addr_i),
        .dmni_wdata_i(dmni_wdata_i), .dmni_rdata_o(dmni_rdata_o),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o),
        .cpu_rdata_o(cpu_rdata_o), .cpu_starve_o(cpu_starve_o), .stall_cnt_o(stall_cnt_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    dmni_mem_arbiter #(.STARVE_LIMIT(16), .CNT_WIDTH(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_ni),
        .dmni_req_i(dmni_req_i), .dmni_we_i(dmni_we_i), .dmni_addr_i(dmni_addr_i),
        .dmni_wdata_i(dmni_wdata_i), .dmni_rdata_o(dmni_rdata4),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_gnt_o(cpu_gnt4), .cpu_rvalid_o(cpu_rvalid4),
        .cpu_rdata_o(cpu_rdata4), .cpu_starve_o(cpu_starve4), .stall_cnt_o(stall_cnt4),
        .mem_we_o(mem_we4), .mem_addr_o(mem_addr4), .mem_wdata_o(mem_wdata4),
        .mem_rdata_i(mem_rdata_i)
    );

    // Synchronous-read memory driven by the DUT's memory port (16 words).
    logic [31:0] tb_mem [16];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we_o[b]) tb_mem[mem_addr_o[5:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
        mem_rdata_i <= tb_mem[mem_addr_o[5:2]];
    end

    // Reference model state
    logic [31:0] model_mem [16];
    logic        m_pend_cpu, m_pend_dmni;
    logic [31:0] m_pend_data, m_dmni_data, m_cpu_data, m_hold_addr, m_hold_wdata;
    int          m_wait, m_stall, m_stall4;
    logic        m_starve;

    // Observations captured at the mid-cycle sample point
    logic        obs_gnt, obs_rvalid, obs_starve;
    logic [31:0] obs_rdata, obs_dmni_rdata, obs_addr, obs_wdata;
    logic [3:0]  obs_we, obs_stall4;
    logic [15:0] obs_stall;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend_cpu = 1'b0; m_pend_dmni = 1'b0;
        m_pend_data = 32'h0; m_dmni_data = 32'h0; m_cpu_data = 32'h0;
        m_hold_addr = 32'h0; m_hold_wdata = 32'h0;
        m_wait = 0; m_stall = 0; m_stall4 = 0; m_starve = 1'b0;
    endtask

    task automatic cycle(input logic rst, input logic dreq, input logic [3:0] dwe,
                         input logic [31:0] daddr, input logic [31:0] dwd,
                         input logic creq, input logic [3:0] cwe,
                         input logic [31:0] caddr, input logic [31:0] cwd);
        logic        gnt_e, stall_e;
        logic [3:0]  we_e;
        logic [31:0] addr_e, wd_e, crd_e;
        @(negedge clk);
        rst_ni = rst;
        dmni_req_i = dreq; dmni_we_i = dwe; dmni_addr_i = daddr; dmni_wdata_i = dwd;
        cpu_req_i = creq; cpu_we_i = cwe; cpu_addr_i = caddr; cpu_wdata_i = cwd;
        if (!rst) model_reset();
        gnt_e = rst && !dreq && creq;
        if (rst && dreq) begin
            we_e = dwe; addr_e = daddr; wd_e = dwd;
        end else if (gnt_e) begin
            we_e = cwe; addr_e = caddr; wd_e = cwd;
        end else begin
            we_e = 4'h0; addr_e = m_hold_addr; wd_e = m_hold_wdata;
        end
        crd_e = m_pend_cpu ? m_pend_data : m_cpu_data;
        #2;
        check_eq("cpu_gnt", {31'h0, cpu_gnt_o}, {31'h0, gnt_e});
        check_eq("mem_we", {28'h0, mem_we_o}, {28'h0, we_e});
        check_eq("mem_addr", mem_addr_o, addr_e);
        check_eq("mem_wdata", mem_wdata_o, wd_e);
        check_eq("cpu_rvalid", {31'h0, cpu_rvalid_o}, {31'h0, m_pend_cpu});
        check_eq("cpu_rdata", cpu_rdata_o, crd_e);
        check_eq("cpu_starve", {31'h0, cpu_starve_o}, {31'h0, m_starve});
        check_eq("stall_cnt", {16'h0, stall_cnt_o}, m_stall);
        check_eq("stall_cnt4", {28'h0, stall_cnt4}, m_stall4);
        check_eq("d4_ctrl", {28'h0, cpu_gnt4, cpu_rvalid4, cpu_starve4, 1'b0},
                 {28'h0, gnt_e, m_pend_cpu, m_starve, 1'b0});
        check_eq("d4_port", mem_addr4 ^ mem_wdata4 ^ {28'h0, mem_we4} ^ cpu_rdata4,
                 addr_e ^ wd_e ^ {28'h0, we_e} ^ crd_e);
        if (m_pend_dmni) begin
            check_eq("dmni_rdata", dmni_rdata_o, m_dmni_data);
            check_eq("dmni_rdata4", dmni_rdata4, m_dmni_data);
        end
        obs_gnt = cpu_gnt_o; obs_rvalid = cpu_rvalid_o; obs_starve = cpu_starve_o;
        obs_rdata = cpu_rdata_o; obs_dmni_rdata = dmni_rdata_o; obs_addr = mem_addr_o;
        obs_wdata = mem_wdata_o; obs_we = mem_we_o; obs_stall = stall_cnt_o;
        obs_stall4 = stall_cnt4;
        @(posedge clk);
        if (rst) begin
            if (m_pend_cpu) m_cpu_data = m_pend_data;
            m_pend_cpu  = gnt_e && (cwe == 4'h0);
            m_pend_data = model_mem[caddr[5:2]];
            m_pend_dmni = dreq && (dwe == 4'h0);
            m_dmni_data = model_mem[daddr[5:2]];
            stall_e  = creq && !gnt_e;
            m_wait   = stall_e ? m_wait + 1 : 0;
            m_starve = (m_wait >= 16);
            if (stall_e) begin
                m_stall  = (m_stall < 65535) ? m_stall + 1 : 65535;
                m_stall4 = (m_stall4 < 15) ? m_stall4 + 1 : 15;
            end
            if (dreq || creq) begin
                m_hold_addr = addr_e; m_hold_wdata = wd_e;
            end
            for (int b = 0; b < 4; b++) begin
                if (we_e[b]) model_mem[addr_e[5:2]][8*b +: 8] = wd_e[8*b +: 8];
            end
        end
    endtask

    task automatic idle(input logic rst);
        cycle(rst, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    logic        c_req, d_req;
    logic [3:0]  c_we, d_we;
    logic [31:0] c_addr, c_wd, d_addr, d_wd;
    logic        r_rst;
    int          d_burst;

    initial begin
        rst_ni = 1'b0; dmni_req_i = 1'b0; dmni_we_i = 4'h0; dmni_addr_i = 32'h0;
        dmni_wdata_i = 32'h0; cpu_req_i = 1'b0; cpu_we_i = 4'h0; cpu_addr_i = 32'h0;
        cpu_wdata_i = 32'h0;
        for (int i = 0; i < 16; i++) begin
            tb_mem[i] = $urandom;
            model_mem[i] = tb_mem[i];
        end
        tb_mem[0] = 32'hDEAD_BEEF;
        model_mem[0] = 32'hDEAD_BEEF;
        model_reset();

        idle(1'b0);
        idle(1'b0);
        check_eq("reset_rvalid", {31'h0, obs_rvalid}, 32'h0);
        check_eq("reset_stall", {16'h0, obs_stall}, 32'h0);
        idle(1'b1);

        // CPU read of 0x100 returns DEADBEEF one cycle after the grant
        cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0000_0100, 32'h0);
        check_eq("rd_gnt", {31'h0, obs_gnt}, 32'h1);
        idle(1'b1);
        check_eq("rd_rvalid", {31'h0, obs_rvalid}, 32'h1);
        check_eq("rd_data", obs_rdata, 32'hDEAD_BEEF);

        // CPU write: routed in the grant cycle, no rvalid afterwards
        cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678);
        check_eq("wr_we", {28'h0, obs_we}, 32'hF);
        check_eq("wr_addr", obs_addr, 32'h0000_0040);
        check_eq("wr_wdata", obs_wdata, 32'h1234_5678);
        idle(1'b1);
        check_eq("wr_no_rvalid", {31'h0, obs_rvalid}, 32'h0);

        // DMNI holds memory 20 cycles while CPU read waits
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 4'h0, 32'(i * 4), 32'h0, 1'b1, 4'h0, 32'h0000_0008, 32'h0);
            check_eq("starve_gnt", {31'h0, obs_gnt}, 32'h0);
            if (i == 15) check_eq("starve_pre", {31'h0, obs_starve}, 32'h0);
            if (i == 16) check_eq("starve_on", {31'h0, obs_starve}, 32'h1);
        end
        cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0000_0008, 32'h0);
        check_eq("starve_grant", {31'h0, obs_gnt}, 32'h1);
        check_eq("stall_20", {16'h0, obs_stall}, 32'd20);
        check_eq("stall4_sat", {28'h0, obs_stall4}, 32'd15);
        idle(1'b1);
        check_eq("starve_clear", {31'h0, obs_starve}, 32'h0);

        // CPU read then DMNI read on the next cycle
        cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0000_0024, 32'h0);
        cycle(1'b1, 1'b1, 4'h0, 32'h0000_0038, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        check_eq("hand_rvalid", {31'h0, obs_rvalid}, 32'h1);
        check_eq("hand_rdata", obs_rdata, model_mem[9]);
        idle(1'b1);
        check_eq("hand_dmni", obs_dmni_rdata, model_mem[14]);

        // Reset right after a CPU read grant discards the read
        cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
        idle(1'b0);
        check_eq("rst_rvalid", {31'h0, obs_rvalid}, 32'h0);
        cycle(1'b0, 1'b1, 4'hF, 32'h0000_0004, 32'hFFFF_FFFF, 1'b1, 4'h3, 32'h8, 32'h1);
        check_eq("rst_we", {28'h0, obs_we}, 32'h0);
        idle(1'b1);
        check_eq("post_rst_rvalid", {31'h0, obs_rvalid}, 32'h0);
        cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0000_0014, 32'h0);
        idle(1'b1);
        check_eq("post_rst_read", obs_rdata, model_mem[5]);

        // Randomized traffic
        c_req = 1'b0; c_we = 4'h0; c_addr = 32'h0; c_wd = 32'h0; d_burst = 0;
        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom_range(0, 299) != 0);
            if (d_burst > 0) begin
                d_req = 1'b1; d_burst--;
            end else if ($urandom_range(0, 5) == 0) begin
                d_req = 1'b1; d_burst = $urandom_range(0, 23);
            end else begin
                d_req = 1'b0;
            end
            d_we   = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
            d_addr = $urandom;
            d_wd   = $urandom;
            if (!c_req && ($urandom_range(0, 9) < 6)) begin
                c_req  = 1'b1;
                c_we   = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
                c_addr = $urandom;
                c_wd   = $urandom;
            end
            cycle(r_rst, d_req, d_we, d_addr, d_wd, c_req, c_we, c_addr, c_wd);
            if (r_rst && !d_req && c_req) c_req = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
